accum_sequencer: RTL and testbench
==================================

Name: accum_sequencer

Overview:
- Controller that sequences the spectral accumulation datapath.
- Reads the ADC sample FIFO once per trigger (one measurement = FRAME_LEN samples) and tags each read with its point index and measurement index.
- Gates accumulation to the point window only, counts MEASURES measurements, then hands the finished sum to the readout logic with a valid/ack handshake.
- Sits between the ADC FIFO and the accumulator.

Parameters:
- FRAME_LEN, 16, samples read from the FIFO per measurement (≥ POINT_OFS+POINTS).
- POINT_OFS, 5, index of the first accumulated sample in a frame.
- POINTS, 10, number of accumulated points per frame.
- MEASURES, 100, measurements per accumulation run (1..2^17).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- start  in  1  1-cycle pulse; begins a run (ignored unless IDLE)
- abort  in  1  level; returns to IDLE from any state
- trig  in  1  laser/measurement trigger; synchronous to clk, rising edge used
- fifo_empty  in  1  ADC FIFO empty flag
- rdreq  out  1  FIFO read request
- acc_en  out  1  accumulate this sample (rdreq and point inside window)
- acc_clr  out  1  1-cycle clear pulse to the accumulator
- cnt_point  out  11  index of the sample being read in the current frame
- cnt_measure  out  17  index of the current measurement
- busy  out  1  high in any state except IDLE
- res_valid  out  1  accumulated result stable and available
- res_ack  in  1  readout has taken the result

Behaviour:
- Reset (async, rst=1): state=IDLE; cnt_point=0; cnt_measure=0; res_valid=0; acc_clr=0; trig edge register=0.
- Outputs in reset: rdreq=0, acc_en=0, busy=0.
- States:
  - IDLE: start → CLEAR.
  - CLEAR: acc_clr=1 for exactly this cycle; cnt_point=0; cnt_measure=0 → ARM.
  - ARM: wait for a trig rising edge (trig=1 while the previous-cycle trig=0) → READ. Edges seen in any other state are ignored.
  - READ:
    - rdreq = !fifo_empty, combinational.
    - On each cycle with rdreq=1, cnt_point increments after the cycle.
    - During a rdreq cycle, cnt_point and cnt_measure describe the sample being read.
    - When the read with cnt_point==FRAME_LEN-1 completes:
      - cnt_point returns to 0.
      - If cnt_measure==MEASURES-1 → DONE.
      - Otherwise cnt_measure increments → ARM.
  - DONE:
    - res_valid=1; counters are held.
    - res_ack=1 → IDLE with res_valid=0 on the next cycle.
    - start in DONE is ignored.
- acc_en = rdreq && POINT_OFS ≤ cnt_point < POINT_OFS+POINTS.
- rdreq and acc_en are 0 in every state except READ.
- FIFO empty mid-frame: stall. No read, counters hold, no timeout.
- abort: synchronous; has priority over all transitions. Next state is IDLE, counters clear, res_valid=0, no acc_clr.
  - abort and start in the same cycle: abort wins.
- Reset mid-run: immediate return to the reset state. The accumulator is not cleared until the next start (via CLEAR).
- MEASURES=1: a single frame, then DONE.
- trig held high across ARM re-entry does not re-trigger; a fresh rising edge is required.
- Counter widths are fixed at 11 and 17 bits. Parameters exceeding them are illegal; check with an elaboration-time assertion.

Decomposition:
- Shared package accum_pkg holds:
  - state enum (IDLE, CLEAR, ARM, READ, DONE)
  - widths PT_W=11, MS_W=17
  - default POINTS/MEASURES/POINT_OFS.
- One natural sub-module, trig_edge: a registered rising-edge detector on trig. Everything else stays flat.

Test Plan:
- Normal run, FRAME_LEN=16, MEASURES=3, FIFO never empty, trig pulse after each ARM:
  - acc_clr once after start;
  - exactly 48 rdreq;
  - acc_en on cnt_point 5..14 only, so 30 acc_en;
  - cnt_measure steps 0→1→2;
  - res_valid rises after the 48th read;
  - res_ack → IDLE, busy=0.
- FIFO stalls: fifo_empty=1 for 4 cycles at cnt_point=7 → rdreq=0 and counters frozen during the stall; the frame still completes with 16 reads.
- Trig held high for 40 cycles spanning the end of frame 0 → no second frame starts until trig falls and rises again.
- abort at cnt_measure=1, cnt_point=9, asserted together with start → next cycle IDLE, counters 0, rdreq=0, no acc_clr.
- Async rst asserted in READ mid-frame, between clock edges → outputs 0 immediately; after release, start → acc_clr pulse and a full run.
- MEASURES=1 edge case plus start pulsed in DONE: one frame of 16 reads, then DONE; start ignored; res_valid held until res_ack.

Source files
------------

// File: rtl/accum_pkg.sv
// rtl/accum_pkg.sv - shared types, widths and default parameters for the accumulation sequencer
package accum_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        READ,
        DONE
    } state_t;

    localparam int PT_W = 11;
    localparam int MS_W = 17;

    localparam int DEF_FRAME_LEN = 16;
    localparam int DEF_POINT_OFS = 5;
    localparam int DEF_POINTS    = 10;
    localparam int DEF_MEASURES  = 100;

endpackage

// File: rtl/trig_edge.sv
// rtl/trig_edge.sv - registered rising-edge detector for the measurement trigger
// Ports: clk, rst (async, active high), trig (synchronous trigger level),
//        rise (high while trig=1 and the previous-cycle trig was 0)
module trig_edge (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rise
);

    logic trig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    assign rise = trig & ~trig_q;

endmodule

// File: rtl/accum_sequencer.sv
// rtl/accum_sequencer.sv - sequences FIFO reads, point gating and measurement counting for accumulation
// Ports: clk, rst (async, active high); start, abort, trig, fifo_empty, res_ack (controls in);
//        rdreq, acc_en, acc_clr (datapath strobes); cnt_point, cnt_measure (sample tags);
//        busy, res_valid (status)
module accum_sequencer
    import accum_pkg::*;
#(
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int POINT_OFS = DEF_POINT_OFS,
    parameter int POINTS    = DEF_POINTS,
    parameter int MEASURES  = DEF_MEASURES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    input  logic            trig,
    input  logic            fifo_empty,
    output logic            rdreq,
    output logic            acc_en,
    output logic            acc_clr,
    output logic [PT_W-1:0] cnt_point,
    output logic [MS_W-1:0] cnt_measure,
    output logic            busy,
    output logic            res_valid,
    input  logic            res_ack
);

    if (FRAME_LEN < 1 || FRAME_LEN > (1 << PT_W) || POINT_OFS < 0 || POINTS < 0 ||
        POINT_OFS + POINTS > FRAME_LEN || MEASURES < 1 || MEASURES > (1 << MS_W)) begin : g_param_check
        $error("accum_sequencer: parameters exceed counter widths or frame length");
    end

    localparam logic [PT_W-1:0] LAST_PT = PT_W'(FRAME_LEN - 1);
    localparam logic [MS_W-1:0] LAST_MS = MS_W'(MEASURES - 1);

    state_t state;
    logic   trig_rise;
    logic   in_window;

    trig_edge u_trig_edge (
        .clk  (clk),
        .rst  (rst),
        .trig (trig),
        .rise (trig_rise)
    );

    // Compare in 32 bits so a window ending exactly at 2^PT_W does not wrap.
    assign in_window = (32'(cnt_point) >= 32'(POINT_OFS)) &&
                       (32'(cnt_point) <  32'(POINT_OFS + POINTS));

    assign busy   = (state != IDLE);
    assign rdreq  = (state == READ) && !fifo_empty;
    assign acc_en = rdreq && in_window;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt_point   <= '0;
            cnt_measure <= '0;
            res_valid   <= 1'b0;
            acc_clr     <= 1'b0;
        end else if (abort) begin
            // Abort leaves the accumulator contents alone; only CLEAR wipes it.
            state       <= IDLE;
            cnt_point   <= '0;
            cnt_measure <= '0;
            res_valid   <= 1'b0;
            acc_clr     <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CLEAR;
                        acc_clr <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt_point   <= '0;
                    cnt_measure <= '0;
                    state       <= ARM;
                end
                ARM: begin
                    if (trig_rise) begin
                        state <= READ;
                    end
                end
                READ: begin
                    // An empty FIFO simply stalls the frame; counters hold.
                    if (!fifo_empty) begin
                        if (cnt_point == LAST_PT) begin
                            cnt_point <= '0;
                            if (cnt_measure == LAST_MS) begin
                                state     <= DONE;
                                res_valid <= 1'b1;
                            end else begin
                                cnt_measure <= cnt_measure + 1'b1;
                                state       <= ARM;
                            end
                        end else begin
                            cnt_point <= cnt_point + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ack) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accum_sequencer.sv
// tb/tb_accum_sequencer.sv - self-checking bench for accum_sequencer
module tb_accum_sequencer;
    import accum_pkg::*;

    localparam int F   = DEF_FRAME_LEN;
    localparam int OFS = DEF_POINT_OFS;
    localparam int NP  = DEF_POINTS;
    localparam int M0  = 3;
    localparam int M1  = 1;

    logic clk;
    logic rst, start, abort, trig, fifo_empty, res_ack;

    logic a_rd, a_en, a_clr, a_bsy, a_rv;
    logic [PT_W-1:0] a_pt;
    logic [MS_W-1:0] a_ms;
    logic b_rd, b_en, b_clr, b_bsy, b_rv;
    logic [PT_W-1:0] b_pt;
    logic [MS_W-1:0] b_ms;

    logic s_rd, s_en, s_clr, s_bsy, s_rv;
    logic [PT_W-1:0] s_pt;
    logic [MS_W-1:0] s_ms;
    int sel;

    int n_checks = 0;
    int n_fail   = 0;

    accum_sequencer #(.FRAME_LEN(F), .POINT_OFS(OFS), .POINTS(NP), .MEASURES(M0)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .fifo_empty(fifo_empty), .rdreq(a_rd), .acc_en(a_en), .acc_clr(a_clr),
        .cnt_point(a_pt), .cnt_measure(a_ms), .busy(a_bsy), .res_valid(a_rv),
        .res_ack(res_ack)
    );

    accum_sequencer #(.FRAME_LEN(F), .POINT_OFS(OFS), .POINTS(NP), .MEASURES(M1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .fifo_empty(fifo_empty), .rdreq(b_rd), .acc_en(b_en), .acc_clr(b_clr),
        .cnt_point(b_pt), .cnt_measure(b_ms), .busy(b_bsy), .res_valid(b_rv),
        .res_ack(res_ack)
    );

    always_comb begin
        if (sel == 1) begin
            s_rd = b_rd; s_en = b_en; s_clr = b_clr; s_bsy = b_bsy; s_rv = b_rv;
            s_pt = b_pt; s_ms = b_ms;
        end else begin
            s_rd = a_rd; s_en = a_en; s_clr = a_clr; s_bsy = a_bsy; s_rv = a_rv;
            s_pt = a_pt; s_ms = a_ms;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic st, ab, tg, fe, ak;
        logic rd, en, clr, bsy, rv;
        int   pt, ms;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    // Apply inputs just after the falling edge, then let combinational outputs settle.
    task automatic cyc(input logic st, input logic ab, input logic tg, input logic fe, input logic ak);
        @(negedge clk);
        start = st; abort = ab; trig = tg; fifo_empty = fe; res_ack = ak;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0; fifo_empty = 1'b1; res_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: reads are numbered 0..F*M-1; read k carries point k%F and measure k/F.
    // Each frame needs a fresh trig rise observed while waiting for it.
    task automatic run_model(input int sel_i, input int m, input int p_empty, input int p_trig,
                             input logic start_in_done, input string tag);
        int reads, delay, dwait, ack_at, n_rd, n_en, n_clr, p;
        logic waiting, reading, done, active, finished, prev, rise, o_wait, o_read;
        logic st, tg, fe, ak, e_rd, e_en;
        sel = sel_i;
        reads = 0; delay = 0; dwait = 0; n_rd = 0; n_en = 0; n_clr = 0;
        ack_at = $urandom_range(1, 5);
        waiting = 0; reading = 0; done = 0; active = 0; finished = 0;
        prev = trig;
        for (int c = 0; c < 4000 && !finished; c++) begin
            st = (c == 0);
            tg = ($urandom_range(0, 99) < p_trig);
            fe = ($urandom_range(0, 99) < p_empty);
            ak = done && (dwait >= ack_at);
            if (done && !ak && start_in_done) st = $urandom_range(0, 1);
            cyc(st, 1'b0, tg, fe, ak);
            p = reads % F;
            e_rd = reading && !fe;
            e_en = e_rd && (p >= OFS) && (p < OFS + NP);
            chk({tag, "_rdreq"}, s_rd, e_rd);
            chk({tag, "_acc_en"}, s_en, e_en);
            chk({tag, "_acc_clr"}, s_clr, delay == 1);
            chk({tag, "_busy"}, s_bsy, active);
            chk({tag, "_res_valid"}, s_rv, done);
            if (e_rd) begin
                chk({tag, "_cnt_point"}, s_pt, p);
                chk({tag, "_cnt_measure"}, s_ms, reads / F);
            end
            if (done) begin
                chk({tag, "_done_point"}, s_pt, 0);
                chk({tag, "_done_measure"}, s_ms, m - 1);
            end
            n_rd += int'(s_rd); n_en += int'(s_en); n_clr += int'(s_clr);
            rise = tg && !prev;
            prev = tg;
            o_wait = waiting; o_read = reading;
            if (o_wait && rise) begin
                waiting = 0; reading = 1;
            end
            if (o_read && !fe) begin
                reads++;
                if (reads % F == 0) begin
                    reading = 0;
                    if (reads == F * m) done = 1;
                    else waiting = 1;
                end
            end
            if (delay > 0) begin
                delay--;
                if (delay == 0) waiting = 1;
            end
            if (c == 0) begin
                delay = 1; active = 1;
            end
            if (ak) begin
                done = 0; active = 0; finished = 1;
            end else if (done) begin
                dwait++;
            end
        end
        chk({tag, "_completed"}, finished, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_post_busy"}, s_bsy, 1'b0);
        chk({tag, "_post_res_valid"}, s_rv, 1'b0);
        chk({tag, "_post_rdreq"}, s_rd, 1'b0);
        chk({tag, "_total_rdreq"}, n_rd, F * m);
        chk({tag, "_total_acc_en"}, n_en, NP * m);
        chk({tag, "_total_acc_clr"}, n_clr, 1);
        sel = 0;
    endtask

    initial begin
        int cnt;
        sel = 0;
        rst = 1'b1; start = 1'b0; abort = 1'b0; trig = 1'b0; fifo_empty = 1'b0; res_ack = 1'b0;

        //            st ab tg fe ak   rd en clr bsy rv  pt ms
        tbl[0]  = '{1'b1,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
        tbl[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b1,1'b0, 0,0};
        tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 0,0};
        tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 0,0};
        tbl[4]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 0,0};
        tbl[5]  = '{1'b0,1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b1,1'b0, 1,0};
        tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 1,0};
        tbl[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 2,0};
        tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 3,0};
        tbl[9]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, 4,0};
        tbl[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0, 5,0};
        tbl[11] = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b1,1'b0, 6,0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 0,0};

        #12;
        chk("reset_rdreq", a_rd, 1'b0);
        chk("reset_acc_en", a_en, 1'b0);
        chk("reset_acc_clr", a_clr, 1'b0);
        chk("reset_busy", a_bsy, 1'b0);
        chk("reset_res_valid", a_rv, 1'b0);
        chk("reset_cnt_point", a_pt, 0);
        chk("reset_cnt_measure", a_ms, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].st, tbl[i].ab, tbl[i].tg, tbl[i].fe, tbl[i].ak);
            chk($sformatf("vec%0d_rdreq", i), a_rd, tbl[i].rd);
            chk($sformatf("vec%0d_acc_en", i), a_en, tbl[i].en);
            chk($sformatf("vec%0d_acc_clr", i), a_clr, tbl[i].clr);
            chk($sformatf("vec%0d_busy", i), a_bsy, tbl[i].bsy);
            chk($sformatf("vec%0d_res_valid", i), a_rv, tbl[i].rv);
            chk($sformatf("vec%0d_cnt_point", i), a_pt, tbl[i].pt);
            chk($sformatf("vec%0d_cnt_measure", i), a_ms, tbl[i].ms);
        end

        // FIFO stall at point 7
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cnt = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cnt += int'(a_rd);
        end
        chk("stall_pre_reads", cnt, 7);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("stall_rdreq", a_rd, 1'b0);
            chk("stall_cnt_point", a_pt, 7);
            chk("stall_cnt_measure", a_ms, 0);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            cnt += int'(a_rd);
        end
        chk("stall_frame_reads", cnt, F);
        chk("stall_next_measure", a_ms, 1);
        chk("stall_point_wrap", a_pt, 0);

        // trig held high across the end of frame 0, then abort+start at measure 1 point 9
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            cnt += int'(a_rd);
        end
        chk("held_trig_reads", cnt, F);
        chk("held_trig_measure", a_ms, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("held_trig_low_rdreq", a_rd, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("held_trig_edge_rdreq", a_rd, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("retrig_rdreq", a_rd, 1'b1);
        chk("retrig_measure", a_ms, 1);
        chk("retrig_point", a_pt, 0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_at_point", a_pt, 9);
        chk("abort_at_measure", a_ms, 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_busy", a_bsy, 1'b0);
        chk("abort_rdreq", a_rd, 1'b0);
        chk("abort_point", a_pt, 0);
        chk("abort_measure", a_ms, 0);
        chk("abort_acc_clr", a_clr, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_no_clear", a_clr, 1'b0);
        chk("abort_idle", a_bsy, 1'b0);

        // asynchronous reset mid-frame
        do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_rst_rdreq", a_rd, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rdreq", a_rd, 1'b0);
        chk("async_rst_acc_en", a_en, 1'b0);
        chk("async_rst_busy", a_bsy, 1'b0);
        chk("async_rst_point", a_pt, 0);
        chk("async_rst_measure", a_ms, 0);
        chk("async_rst_res_valid", a_rv, 1'b0);
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_model(0, M0, 0, 30, 1'b0, "after_rst");

        do_reset();
        run_model(0, M0, 0, 35, 1'b0, "normal");
        for (int r = 0; r < 3; r++) begin
            do_reset();
            run_model(0, M0, 25, 20, 1'b1, $sformatf("rand%0d", r));
        end

        do_reset();
        run_model(1, M1, 0, 30, 1'b1, "single");
        do_reset();
        run_model(1, M1, 30, 25, 1'b1, "single_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
